ps2_scan_fifo: RTL and testbench

PS2_SCAN_FIFO -- requirements
Module: ps2_scan_fifo

---
 rtl/ps2_scan_fifo.sv | 144 ++++++++++++++
 tb/tb_ps2_scan_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo: PS/2 keyboard receiver feeding a show-ahead scancode FIFO,
// with sticky error flags and a seven-segment display of the latest bytes.
module ps2_scan_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int HEX_DIGITS     = 6,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic [7*HEX_DIGITS-1:0]       hex_seg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int DW = 8 * (HEX_DIGITS / 2);
  localparam logic [111:0] SEG = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                  7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t         state_q, state_d;
  logic [1:0]     c_sync_q, d_sync_q;
  logic           c_prev_q;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sr_q, sr_d;
  logic           par_q, par_d;
  logic [TW-1:0]  to_q, to_d;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wp_q, rp_q;
  logic [AW:0]    cnt_q, cnt_d;
  logic           ovf_q, perr_q, ferr_q;
  logic [DW-1:0]  disp_q;
  logic           fall, dat, timeout, frame_ok, set_perr, set_ferr;
  logic           empty, full, pop, push;

  assign fall    = c_prev_q & ~c_sync_q[1];
  assign dat     = d_sync_q[1];
  assign timeout = (state_q != IDLE) && !fall && (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    par_d    = par_q;
    frame_ok = 1'b0;
    set_perr = 1'b0;
    set_ferr = timeout;
    to_d     = (fall || state_q == IDLE) ? '0 : to_q + 1'b1;
    if (timeout) state_d = IDLE;
    else if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = dat ? IDLE : DATA;
          bit_d   = '0;
        end
        DATA: begin
          sr_d    = {dat, sr_q[7:1]};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = dat;
          state_d = STOP;
        end
        default: begin
          state_d  = IDLE;
          set_ferr = !dat;
          set_perr = dat && ((^sr_q) == par_q);
          frame_ok = dat && ((^sr_q) != par_q);
        end
      endcase
    end
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = rd_en && !empty;
  assign push  = frame_ok && (!full || pop);
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q  <= IDLE;
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_prev_q <= 1'b1;
      bit_q    <= '0;
      sr_q     <= '0;
      par_q    <= 1'b0;
      to_q     <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      c_sync_q <= {c_sync_q[0], PS2_CLK};
      d_sync_q <= {d_sync_q[0], PS2_DAT};
      c_prev_q <= c_sync_q[1];
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      par_q    <= par_d;
      to_q     <= to_d;
      wp_q     <= push ? wp_q + 1'b1 : wp_q;
      rp_q     <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q    <= cnt_d;
      ovf_q    <= (frame_ok && full && !pop) || (ovf_q && !clr_err);
      perr_q   <= set_perr || (perr_q && !clr_err);
      ferr_q   <= set_ferr || (ferr_q && !clr_err);
      // dropped frames still update the display
      disp_q   <= frame_ok ? ((disp_q << 8) | DW'(sr_q)) : disp_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wp_q] <= sr_q;
  end

  assign rd_data    = empty ? 8'h00 : mem[rp_q];
  assign rd_valid   = !empty;
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

  for (genvar i = 0; i < HEX_DIGITS; i++) begin : g_dig
    logic [3:0] nib;
    assign nib = disp_q[4*i +: 4];
    assign hex_seg[7*i +: 7] = SEG[7*nib +: 7] ^ {7{SEG_ACTIVE_LOW}};
  end
endmodule

// File: tb/tb_ps2_scan_fifo.sv
// tb_ps2_scan_fifo: table-driven, directed and randomized checks of ps2_scan_fifo
// against a queue-based reference model.
module tb_ps2_scan_fifo;
  localparam int D  = 16;
  localparam int HD = 6;
  localparam int TO = 200;
  localparam int H  = 4;
  localparam logic [6:0] SEG_AL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic CLK = 0, reset = 0, PS2_CLK = 1, PS2_DAT = 1, rd_en = 0, clr_err = 0;
  logic [7:0]      rd_data;
  logic            rd_valid, overflow, parity_err, frame_err;
  logic [4:0]      count;
  logic [7*HD-1:0] hex_seg;

  ps2_scan_fifo #(.FIFO_DEPTH(D), .HEX_DIGITS(HD), .TIMEOUT_CYCLES(TO), .SEG_ACTIVE_LOW(1)) dut (
    .CLK(CLK), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err), .hex_seg(hex_seg)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] d;
    logic       p, s, ev, ep, ef;
  } vec_t;

  int         tests = 0, fails = 0;
  logic [7:0] q[$];
  logic [7:0] m_disp [3];
  logic       m_ovf, m_perr, m_ferr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [41:0] exp_seg();
    logic [41:0] r;
    for (int k = 0; k < 3; k++) begin
      r[14*k +: 7]     = SEG_AL[m_disp[k][3:0]];
      r[14*k + 7 +: 7] = SEG_AL[m_disp[k][7:4]];
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(q.size() != 0));
    chk({tag, ".rd_data"}, 64'(rd_data), 64'(q.size() != 0 ? q[0] : 8'h00));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".parity_err"}, 64'(parity_err), 64'(m_perr));
    chk({tag, ".frame_err"}, 64'(frame_err), 64'(m_ferr));
    chk({tag, ".hex_seg"}, 64'(hex_seg), 64'(exp_seg()));
  endtask

  function automatic void m_frame(input logic [7:0] d, input logic p, s, pop);
    if (pop && q.size() != 0) void'(q.pop_front());
    if (!s) m_ferr = 1;
    else if (p != ~^d) m_perr = 1;
    else begin
      if (q.size() == D) m_ovf = 1;
      else q.push_back(d);
      m_disp[2] = m_disp[1];
      m_disp[1] = m_disp[0];
      m_disp[0] = d;
    end
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge CLK);
    PS2_DAT = b;
    PS2_CLK = 1;
    repeat (H) @(negedge CLK);
    PS2_CLK = 0;
    repeat (H) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] d, input logic p, s, pop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    @(negedge CLK);
    PS2_DAT = s;
    PS2_CLK = 1;
    repeat (H) @(negedge CLK);
    PS2_CLK = 0;
    // rd_en lands on the edge that writes the stop-bit frame
    repeat (2) @(negedge CLK);
    rd_en = pop;
    @(negedge CLK);
    rd_en = 0;
    repeat (H) @(negedge CLK);
    PS2_CLK = 1;
    PS2_DAT = 1;
    repeat (4) @(negedge CLK);
    m_frame(d, p, s, pop);
  endtask

  task automatic do_pop();
    @(negedge CLK);
    rd_en = 1;
    @(negedge CLK);
    rd_en = 0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_clr();
    @(negedge CLK);
    clr_err = 1;
    @(negedge CLK);
    clr_err = 0;
    m_ovf = 0; m_perr = 0; m_ferr = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 0; PS2_CLK = 1; PS2_DAT = 1; rd_en = 0; clr_err = 0;
    repeat (2) @(negedge CLK);
    reset = 1;
    q.delete();
    m_ovf = 0; m_perr = 0; m_ferr = 0;
    m_disp = '{8'h00, 8'h00, 8'h00};
  endtask

  initial begin
    vec_t tbl [9];
    logic [7:0] d;
    logic p, s, pp;
    tbl = '{'{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
            '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
            '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};

    do_reset();
    check_all("reset");
    chk("reset.digits", 64'(hex_seg), 64'({HD{7'h40}}));
    do_pop();
    check_all("empty_pop");

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].d, tbl[i].p, tbl[i].s, 1'b0);
      chk("tbl.count", 64'(count), 64'(tbl[i].ev));
      chk("tbl.rd_data", 64'(rd_data), 64'(tbl[i].ev ? tbl[i].d : 8'h00));
      chk("tbl.parity_err", 64'(parity_err), 64'(tbl[i].ep));
      chk("tbl.frame_err", 64'(frame_err), 64'(tbl[i].ef));
      if (i < 2) chk("tbl.digits_1C", 64'(hex_seg[13:0]), 64'({7'h79, 7'h46}));
      check_all("tbl");
      if (tbl[i].ev) do_pop();
      do_clr();
      check_all("tbl.after");
    end

    do_reset();
    for (int k = 0; k <= D; k++) send(8'(k), ~^(8'(k)), 1'b1, 1'b0);
    chk("ovf.count", 64'(count), 64'(D));
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.digits", 64'(hex_seg[13:0]), 64'({7'h79, 7'h40}));
    check_all("ovf");
    for (int k = 0; k < D; k++) begin
      chk("ovf.pop", 64'(rd_data), 64'(k));
      do_pop();
    end
    check_all("ovf.drained");

    do_reset();
    for (int k = 0; k < D; k++) send(8'(k + 8'h20), ~^(8'(k + 8'h20)), 1'b1, 1'b0);
    send(8'hEE, 1'b1, 1'b1, 1'b1);
    chk("wrpop.count", 64'(count), 64'(D));
    chk("wrpop.overflow", 64'(overflow), 64'd0);
    check_all("wrpop");
    for (int k = 0; k < D - 1; k++) do_pop();
    chk("wrpop.tail", 64'(rd_data), 64'h0EE);
    check_all("wrpop.tail");

    do_reset();
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    @(negedge CLK);
    PS2_CLK = 1;
    repeat (TO + 20) @(negedge CLK);
    m_ferr = 1;
    chk("timeout.frame_err", 64'(frame_err), 64'd1);
    chk("timeout.count", 64'(count), 64'd0);
    send(8'hF0, 1'b1, 1'b1, 1'b0);
    chk("timeout.next", 64'(rd_data), 64'h0F0);
    check_all("timeout");

    send(8'h11, 1'b1, 1'b1, 1'b0);
    send(8'h11, 1'b0, 1'b1, 1'b0);
    check_all("prereset");
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    do_reset();
    check_all("midreset");
    chk("midreset.digits", 64'(hex_seg), 64'({HD{7'h40}}));
    send(8'h5A, 1'b1, 1'b1, 1'b0);
    chk("midreset.5A", 64'(rd_data), 64'h05A);
    chk("midreset.count", 64'(count), 64'd1);
    check_all("midreset.after");

    do_reset();
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      p  = ($urandom_range(0, 9) < 8) ? ~^d : ^d;
      s  = $urandom_range(0, 9) != 0;
      pp = $urandom_range(0, 3) == 0;
      send(d, p, s, pp);
      check_all("rnd.frame");
      if ($urandom_range(0, 2) == 0) begin
        do_pop();
        check_all("rnd.pop");
      end
      if ($urandom_range(0, 7) == 0) begin
        do_clr();
        check_all("rnd.clr");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
